// File: rtl/ram_port_pkg.sv
// Shared types and helpers for the multi-channel async-memory port controller.
package ram_port_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ACCESS,
    HOLD,
    RECOV
  } ram_port_state_e;

  localparam int unsigned BYTE_LANES = 2;

  // ACCESS phase length; a programmed 0 still yields one strobe cycle.
  function automatic int unsigned acc_len(input int unsigned cfg);
    return (cfg == 0) ? 1 : cfg;
  endfunction

endpackage

// File: rtl/ram_port_chan.sv
// One memory bus: request latch, SETUP/ACCESS/HOLD/RECOV sequencer and
// registered active-low strobes.
module ram_port_chan
  import ram_port_pkg::*;
#(
  parameter int unsigned ADDR_W = 23,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned WAIT_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic                  we,
  input  logic [BYTE_LANES-1:0] be,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [WAIT_W-1:0]     acc_cyc,
  output logic [DATA_W-1:0]     rdata,
  output logic                  ack,
  output logic                  busy,
  output logic [ADDR_W-2:0]     mem_a,
  output logic [DATA_W-1:0]     mem_dout,
  input  logic [DATA_W-1:0]     mem_din,
  output logic                  mem_doe,
  output logic                  mem_cen,
  output logic                  mem_oen,
  output logic                  mem_wen,
  output logic                  mem_lbn,
  output logic                  mem_ubn
);

  ram_port_state_e       state_q, state_d;
  logic                  we_q, we_d;
  logic [BYTE_LANES-1:0] be_q, be_d;
  logic [ADDR_W-2:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [WAIT_W-1:0]     acc_q, acc_d;
  logic [WAIT_W-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic                  ack_q, ack_d;
  logic                  busy_q, busy_d;
  logic                  doe_q, doe_d;
  logic                  cen_q, cen_d;
  logic                  oen_q, oen_d;
  logic                  wen_q, wen_d;
  logic                  lbn_q, lbn_d;
  logic                  ubn_q, ubn_d;
  logic                  in_seq, in_acc;
  logic                  unused_addr0;

  assign unused_addr0 = addr[0];

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    be_d    = be_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          we_d    = we;
          be_d    = be;
          addr_d  = addr[ADDR_W-1:1];
          wdata_d = wdata;
          acc_d   = acc_cyc;
          state_d = SETUP;
        end
      end
      SETUP: begin
        cnt_d   = WAIT_W'(acc_len(32'(acc_q)) - 1);
        state_d = ACCESS;
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          if (!we_q) rdata_d = mem_din;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q - WAIT_W'(1);
        end
      end
      HOLD:    state_d = RECOV;
      RECOV:   state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Strobes are decoded from the next state so that the registered pins
    // line up with the phase the FSM is entering.
    in_seq = (state_d == SETUP) || (state_d == ACCESS) || (state_d == HOLD);
    in_acc = (state_d == ACCESS);
    cen_d  = !in_seq;
    oen_d  = !(in_acc && !we_d);
    wen_d  = !(in_acc && we_d && (be_d != '0));
    lbn_d  = !(in_acc && (!we_d || be_d[0]));
    ubn_d  = !(in_acc && (!we_d || be_d[1]));
    doe_d  = in_seq && we_d;
    ack_d  = (state_d == HOLD);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      doe_q   <= 1'b0;
      cen_q   <= 1'b1;
      oen_q   <= 1'b1;
      wen_q   <= 1'b1;
      lbn_q   <= 1'b1;
      ubn_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      doe_q   <= doe_d;
      cen_q   <= cen_d;
      oen_q   <= oen_d;
      wen_q   <= wen_d;
      lbn_q   <= lbn_d;
      ubn_q   <= ubn_d;
    end
  end

  assign rdata    = rdata_q;
  assign ack      = ack_q;
  assign busy     = busy_q;
  assign mem_a    = addr_q;
  assign mem_dout = wdata_q;
  assign mem_doe  = doe_q;
  assign mem_cen  = cen_q;
  assign mem_oen  = oen_q;
  assign mem_wen  = wen_q;
  assign mem_lbn  = lbn_q;
  assign mem_ubn  = ubn_q;

endmodule

// File: rtl/ram_port_ctrl.sv
// Multi-channel async-memory port controller: CHANNELS independent buses,
// each with its own handshake and programmable ACCESS length.
module ram_port_ctrl
  import ram_port_pkg::*;
#(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned ADDR_W   = 23,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned WAIT_W   = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [CHANNELS-1:0]              req,
  input  logic [CHANNELS-1:0]              we,
  input  logic [BYTE_LANES*CHANNELS-1:0]   be,
  input  logic [ADDR_W*CHANNELS-1:0]       addr,
  input  logic [DATA_W*CHANNELS-1:0]       wdata,
  input  logic [WAIT_W*CHANNELS-1:0]       acc_cyc,
  output logic [DATA_W*CHANNELS-1:0]       rdata,
  output logic [CHANNELS-1:0]              ack,
  output logic [CHANNELS-1:0]              busy,
  output logic [(ADDR_W-1)*CHANNELS-1:0]   mem_a,
  output logic [DATA_W*CHANNELS-1:0]       mem_dout,
  input  logic [DATA_W*CHANNELS-1:0]       mem_din,
  output logic [CHANNELS-1:0]              mem_doe,
  output logic [CHANNELS-1:0]              mem_cen,
  output logic [CHANNELS-1:0]              mem_oen,
  output logic [CHANNELS-1:0]              mem_wen,
  output logic [CHANNELS-1:0]              mem_lbn,
  output logic [CHANNELS-1:0]              mem_ubn
);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    ram_port_chan #(
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W),
      .WAIT_W(WAIT_W)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .req     (req[g]),
      .we      (we[g]),
      .be      (be[g*BYTE_LANES +: BYTE_LANES]),
      .addr    (addr[g*ADDR_W +: ADDR_W]),
      .wdata   (wdata[g*DATA_W +: DATA_W]),
      .acc_cyc (acc_cyc[g*WAIT_W +: WAIT_W]),
      .rdata   (rdata[g*DATA_W +: DATA_W]),
      .ack     (ack[g]),
      .busy    (busy[g]),
      .mem_a   (mem_a[g*(ADDR_W-1) +: (ADDR_W-1)]),
      .mem_dout(mem_dout[g*DATA_W +: DATA_W]),
      .mem_din (mem_din[g*DATA_W +: DATA_W]),
      .mem_doe (mem_doe[g]),
      .mem_cen (mem_cen[g]),
      .mem_oen (mem_oen[g]),
      .mem_wen (mem_wen[g]),
      .mem_lbn (mem_lbn[g]),
      .mem_ubn (mem_ubn[g])
    );
  end

endmodule

// File: tb/tb_ram_port_ctrl.sv
// Bench for ram_port_ctrl: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a phase-offset model.
module tb_ram_port_ctrl;

  localparam int CH = 4;
  localparam int AW = 23;
  localparam int WW = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [CH-1:0]     req = '0;
  logic [CH-1:0]     we = '0;
  logic [2*CH-1:0]   be = '0;
  logic [AW*CH-1:0]  addr = '0;
  logic [16*CH-1:0]  wdata = '0;
  logic [WW*CH-1:0]  acc_cyc = '0;
  logic [16*CH-1:0]  rdata;
  logic [CH-1:0]     ack, busy;
  logic [(AW-1)*CH-1:0] mem_a;
  logic [16*CH-1:0]  mem_dout;
  logic [16*CH-1:0]  mem_din = '0;
  logic [CH-1:0]     mem_doe, mem_cen, mem_oen, mem_wen, mem_lbn, mem_ubn;

  int checks = 0;
  int errors = 0;

  ram_port_ctrl #(.CHANNELS(CH), .ADDR_W(AW), .DATA_W(16), .WAIT_W(WW)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .be(be), .addr(addr),
    .wdata(wdata), .acc_cyc(acc_cyc), .rdata(rdata), .ack(ack), .busy(busy),
    .mem_a(mem_a), .mem_dout(mem_dout), .mem_din(mem_din), .mem_doe(mem_doe),
    .mem_cen(mem_cen), .mem_oen(mem_oen), .mem_wen(mem_wen),
    .mem_lbn(mem_lbn), .mem_ubn(mem_ubn)
  );

  always #10 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Model: an access is a cycle offset k from the sampling edge.
  // k=1 SETUP, 2..N+1 ACCESS, N+2 HOLD (ack), N+3 RECOV.
  bit          m_act [CH];
  int          m_k   [CH];
  int          m_n   [CH];
  bit          m_we  [CH];
  logic [1:0]  m_be  [CH];
  logic [AW-1:0] m_addr[CH];
  logic [15:0] m_wd  [CH];
  logic [15:0] m_rd  [CH];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < CH; c++) begin
        m_act[c] <= 1'b0; m_k[c] <= 0; m_n[c] <= 1; m_we[c] <= 1'b0;
        m_be[c] <= '0; m_addr[c] <= '0; m_wd[c] <= '0; m_rd[c] <= '0;
      end
    end else begin
      for (int c = 0; c < CH; c++) begin
        if (m_act[c]) begin
          if (m_k[c] == m_n[c] + 1 && !m_we[c]) m_rd[c] <= mem_din[c*16 +: 16];
          m_k[c]   <= m_k[c] + 1;
          m_act[c] <= (m_k[c] + 1 < m_n[c] + 4);
        end else if (req[c]) begin
          m_we[c]   <= we[c];
          m_be[c]   <= be[c*2 +: 2];
          m_addr[c] <= addr[c*AW +: AW];
          m_wd[c]   <= wdata[c*16 +: 16];
          m_n[c]    <= (acc_cyc[c*WW +: WW] == 0) ? 1 : int'(acc_cyc[c*WW +: WW]);
          m_k[c]    <= 1;
          m_act[c]  <= 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      for (int c = 0; c < CH; c++) begin
        bit seq, acc;
        int k, n;
        k = m_k[c];
        n = m_n[c];
        seq = m_act[c] && k >= 1 && k <= n + 2;
        acc = m_act[c] && k >= 2 && k <= n + 1;
        check($sformatf("ch%0d cen", c), 64'(mem_cen[c]), 64'(!seq));
        check($sformatf("ch%0d oen", c), 64'(mem_oen[c]), 64'(!(acc && !m_we[c])));
        check($sformatf("ch%0d wen", c), 64'(mem_wen[c]), 64'(!(acc && m_we[c] && m_be[c] != 0)));
        check($sformatf("ch%0d lbn", c), 64'(mem_lbn[c]), 64'(!(acc && (!m_we[c] || m_be[c][0]))));
        check($sformatf("ch%0d ubn", c), 64'(mem_ubn[c]), 64'(!(acc && (!m_we[c] || m_be[c][1]))));
        check($sformatf("ch%0d doe", c), 64'(mem_doe[c]), 64'(seq && m_we[c]));
        check($sformatf("ch%0d ack", c), 64'(ack[c]), 64'(m_act[c] && k == n + 2));
        check($sformatf("ch%0d busy", c), 64'(busy[c]), 64'(m_act[c]));
        check($sformatf("ch%0d rdata", c), 64'(rdata[c*16 +: 16]), 64'(m_rd[c]));
        if (seq) check($sformatf("ch%0d mem_a", c), 64'(mem_a[c*(AW-1) +: (AW-1)]), 64'(m_addr[c][AW-1:1]));
        if (seq && m_we[c]) check($sformatf("ch%0d mem_dout", c), 64'(mem_dout[c*16 +: 16]), 64'(m_wd[c]));
        check($sformatf("ch%0d oen_wen_overlap", c), 64'(!mem_oen[c] && !mem_wen[c]), 64'(0));
        check($sformatf("ch%0d doe_oen_overlap", c), 64'(mem_doe[c] && !mem_oen[c]), 64'(0));
      end
    end
  end

  // Per-cycle statistics collected by the directed scenarios.
  int first_ack[CH];
  int cen_lo[CH], oen_lo[CH], wen_lo[CH], lbn_lo[CH], ubn_lo[CH], doe_hi[CH];
  int ack3[$];

  task automatic measure(input int cycles, input bit hold);
    for (int c = 0; c < CH; c++) begin
      first_ack[c] = -1; cen_lo[c] = 0; oen_lo[c] = 0; wen_lo[c] = 0;
      lbn_lo[c] = 0; ubn_lo[c] = 0; doe_hi[c] = 0;
    end
    ack3.delete();
    @(posedge clk);
    for (int i = 1; i <= cycles; i++) begin
      @(negedge clk);
      for (int c = 0; c < CH; c++) begin
        cen_lo[c] += int'(!mem_cen[c]);
        oen_lo[c] += int'(!mem_oen[c]);
        wen_lo[c] += int'(!mem_wen[c]);
        lbn_lo[c] += int'(!mem_lbn[c]);
        ubn_lo[c] += int'(!mem_ubn[c]);
        doe_hi[c] += int'(mem_doe[c]);
        if (ack[c]) begin
          if (first_ack[c] < 0) first_ack[c] = i;
          if (c == 3) ack3.push_back(i);
          if (hold) addr[c*AW +: AW] = AW'($urandom);
          else req[c] = 1'b0;
        end
      end
    end
  endtask

  bit hold_r[CH];

  initial begin
    repeat (3) @(negedge clk);
    check("rst cen", 64'(mem_cen), 64'hF);
    check("rst oen_wen", 64'({mem_oen, mem_wen, mem_lbn, mem_ubn}), 64'hFFFF);
    check("rst doe_ack_busy", 64'({mem_doe, ack, busy}), 64'h0);
    check("rst rdata", 64'(rdata), 64'h0);
    check("rst mem_a", 64'(mem_a), 64'h0);
    check("rst mem_dout", 64'(mem_dout), 64'h0);
    rst = 1'b0;
    @(negedge clk);

    // Read ch0, N=3
    we[0] = 1'b0; be[1:0] = 2'b00; addr[AW-1:0] = 23'h000010;
    acc_cyc[3:0] = 4'd3; mem_din[15:0] = 16'hBEEF; req[0] = 1'b1;
    measure(8, 1'b0);
    check("rd ack_cycle", 64'(first_ack[0]), 64'd5);
    check("rd cen_cycles", 64'(cen_lo[0]), 64'd5);
    check("rd oen_cycles", 64'(oen_lo[0]), 64'd3);
    check("rd rdata", 64'(rdata[15:0]), 64'hBEEF);
    check("rd mem_a", 64'(mem_a[AW-2:0]), 64'h8);

    // Write ch2, upper byte only, N=2
    we[2] = 1'b1; be[5:4] = 2'b10; wdata[47:32] = 16'h1234;
    acc_cyc[11:8] = 4'd2; addr[3*AW-1:2*AW] = 23'h000400; req[2] = 1'b1;
    measure(8, 1'b0);
    check("wr ack_cycle", 64'(first_ack[2]), 64'd4);
    check("wr wen_cycles", 64'(wen_lo[2]), 64'd2);
    check("wr ubn_cycles", 64'(ubn_lo[2]), 64'd2);
    check("wr lbn_cycles", 64'(lbn_lo[2]), 64'd0);
    check("wr doe_cycles", 64'(doe_hi[2]), 64'd4);
    check("wr oen_cycles", 64'(oen_lo[2]), 64'd0);

    // acc_cyc=0: ch0 read, ch1 write with be=0
    we[0] = 1'b0; acc_cyc[3:0] = 4'd0; req[0] = 1'b1;
    we[1] = 1'b1; be[3:2] = 2'b00; acc_cyc[7:4] = 4'd0; req[1] = 1'b1;
    measure(7, 1'b0);
    check("z rd ack_cycle", 64'(first_ack[0]), 64'd3);
    check("z rd oen_cycles", 64'(oen_lo[0]), 64'd1);
    check("z wr ack_cycle", 64'(first_ack[1]), 64'd3);
    check("z wr wen_cycles", 64'(wen_lo[1]), 64'd0);
    check("z wr doe_cycles", 64'(doe_hi[1]), 64'd3);

    // All four channels together, N = 1..4
    for (int c = 0; c < CH; c++) begin
      we[c] = 1'b0; acc_cyc[c*WW +: WW] = WW'(c + 1); req[c] = 1'b1;
    end
    measure(10, 1'b0);
    for (int c = 0; c < CH; c++)
      check($sformatf("multi ch%0d ack_cycle", c), 64'(first_ack[c]), 64'(c + 3));

    // Held request on ch3 with N=1: repeats every 5 cycles
    we[3] = 1'b0; acc_cyc[15:12] = 4'd1; req[3] = 1'b1;
    measure(21, 1'b1);
    req[3] = 1'b0;
    check("hold ack_count", 64'(ack3.size()), 64'd4);
    for (int i = 1; i < ack3.size(); i++)
      check("hold period", 64'(ack3[i] - ack3[i-1]), 64'd5);
    repeat (6) @(negedge clk);

    // Reset mid-ACCESS of a write on ch1
    we[1] = 1'b1; be[3:2] = 2'b11; wdata[31:16] = 16'h5555; acc_cyc[7:4] = 4'd8; req[1] = 1'b1;
    @(posedge clk);
    repeat (3) @(negedge clk);
    check("mid wen_active", 64'(mem_wen[1]), 64'd0);
    req[1] = 1'b0;
    #3 rst = 1'b1;
    #1;
    check("async cen", 64'(mem_cen), 64'hF);
    check("async strobes", 64'({mem_oen, mem_wen, mem_lbn, mem_ubn}), 64'hFFFF);
    check("async doe", 64'(mem_doe), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    begin
      int acks, busys;
      acks = 0; busys = 0;
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        acks += int'(ack != 0);
        busys += int'(busy != 0);
      end
      check("post_rst acks", 64'(acks), 64'd0);
      check("post_rst busy", 64'(busys), 64'd0);
    end

    // Randomized traffic
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      mem_din = {$urandom(), $urandom()};
      for (int c = 0; c < CH; c++) begin
        if (req[c]) begin
          if (ack[c] && (!hold_r[c] || $urandom_range(0, 3) == 0)) begin
            req[c] = 1'b0; hold_r[c] = 1'b0;
          end
        end else if ($urandom_range(0, 2) == 0) begin
          req[c] = 1'b1; hold_r[c] = ($urandom_range(0, 7) == 0);
        end
        we[c] = 1'($urandom_range(0, 1));
        be[c*2 +: 2] = 2'($urandom);
        addr[c*AW +: AW] = AW'($urandom);
        wdata[c*16 +: 16] = 16'($urandom);
        acc_cyc[c*WW +: WW] = WW'($urandom_range(0, 6));
      end
    end
    req = '0;
    repeat (15) @(negedge clk);
    check("drain busy", 64'(busy), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
